poly_note_player: RTL and testbench

- Parametrised successor to the single-voice note player: NUM_VOICES independent voices, each with its own note register, duration counter and phase accumulator.
- A single shared frequency_rom and sine_rom are time-multiplexed across the voices; the outputs are summed, scaled and saturated into one 16-bit sample.
- Sits between song_reader/music control and the codec. It keeps the same load / beat / done / generate / ready handshakes, and adds a voice select.

---
 rtl/poly_note_player_pkg.sv | 39 +++
 rtl/poly_note_player_if.sv | 38 +++
 rtl/poly_note_player_voice_timer.sv | 36 +++
 rtl/poly_note_player.sv | 177 +++++++++++++++++
 tb/tb_poly_note_player.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/poly_note_player_pkg.sv
// rtl/poly_note_player_pkg.sv - shared constants, FSM encoding and ROM contents for poly_note_player
//
// Purpose: widths used across the player, the mix FSM state encoding, and the
// contents of the two shared lookup ROMs (frequency step per note, quarter-wave
// sine amplitude per address).
// Ports: none (package).
package poly_note_pkg;

  localparam int PHASE_W     = 22;
  localparam int STEP_W      = 20;
  localparam int SINE_ADDR_W = 10;
  localparam int SAMPLE_W    = 16;
  localparam int NOTE_W      = 6;
  localparam int DUR_W       = 6;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ADDR = 3'd1;
  localparam logic [2:0] S_STEP = 3'd2;
  localparam logic [2:0] S_SINE = 3'd3;
  localparam logic [2:0] S_ACC  = 3'd4;
  localparam logic [2:0] S_OUT  = 3'd5;

  // Phase increment per sample for a note: note * 2^14, so note 0 (rest) never advances.
  function automatic logic [STEP_W-1:0] freq_rom_value(input logic [NOTE_W-1:0] note);
    return {note, 14'd0};
  endfunction

  // Quarter-wave amplitude: parabola a*(2048-a)/32 over a = 0..1023, peaking at 32767.
  function automatic logic [SAMPLE_W-1:0] sine_rom_value(input logic [SINE_ADDR_W-1:0] addr);
    logic [23:0] xa;
    logic [23:0] xb;
    logic [23:0] prod;
    xa   = {14'd0, addr};
    xb   = 24'd2048 - xa;
    prod = xa * xb;
    return SAMPLE_W'(prod >> 5);
  endfunction

endpackage

// File: rtl/poly_note_player_if.sv
// rtl/poly_note_player_if.sv - control/sample bus between music control, codec and poly_note_player
//
// Purpose: bundles the load / beat / generate handshakes and the mixed sample.
// Signals: play_enable, load_new_note, voice_sel, note_to_load, duration_to_load,
//          beat, generate_next_sample (controller -> player);
//          done_with_note, busy, sample_out, new_sample_ready (player -> controller).
// Modports: master = controller side, slave = player side.
interface poly_note_player_if #(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_BITS = 2
);
  import poly_note_pkg::*;

  logic                  play_enable;
  logic                  load_new_note;
  logic [VOICE_BITS-1:0] voice_sel;
  logic [NOTE_W-1:0]     note_to_load;
  logic [DUR_W-1:0]      duration_to_load;
  logic                  beat;
  logic                  generate_next_sample;
  logic [NUM_VOICES-1:0] done_with_note;
  logic                  busy;
  logic [SAMPLE_W-1:0]   sample_out;
  logic                  new_sample_ready;

  modport master (
    output play_enable, load_new_note, voice_sel, note_to_load, duration_to_load,
           beat, generate_next_sample,
    input  done_with_note, busy, sample_out, new_sample_ready
  );

  modport slave (
    input  play_enable, load_new_note, voice_sel, note_to_load, duration_to_load,
           beat, generate_next_sample,
    output done_with_note, busy, sample_out, new_sample_ready
  );

endinterface

// File: rtl/poly_note_player_voice_timer.sv
// rtl/poly_note_player_voice_timer.sv - note register and beat-driven duration counter for one voice
//
// Purpose: holds one voice's note and remaining beat count.
// Ports: clk, reset (sync, active-high); load + note_in/dur_in load the voice;
//        beat_tick decrements a nonzero count; note/count are the held state;
//        done is high while count is zero.
module voice_timer
  import poly_note_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              beat_tick,
  input  logic [NOTE_W-1:0] note_in,
  input  logic [DUR_W-1:0]  dur_in,
  output logic [NOTE_W-1:0] note,
  output logic [DUR_W-1:0]  count,
  output logic              done
);

  // A load in the same cycle as a beat takes priority over the decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      note  <= '0;
      count <= '0;
    end else if (load) begin
      note  <= note_in;
      count <= dur_in;
    end else if (beat_tick && count != '0) begin
      count <= count - DUR_W'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/poly_note_player.sv
// rtl/poly_note_player.sv - NUM_VOICES-voice sine note player sharing one frequency ROM and one sine ROM
//
// Purpose: per-voice note/duration/phase state; on each sample request the FSM
// walks every voice through the shared ROMs, sums the signed voice samples,
// shifts by MIX_SHIFT and saturates to a 16-bit sample.
// Ports: clk; reset (sync, active-high); bus (slave side of poly_note_player_if):
//        load/voice_sel/note/duration inputs, beat, play_enable, generate_next_sample,
//        done_with_note, busy, sample_out, new_sample_ready.
module poly_note_player
  import poly_note_pkg::*;
#(
  parameter int NUM_VOICES = 3,
  parameter int VOICE_BITS = 2,
  parameter int MIX_SHIFT  = 1
) (
  input  logic              clk,
  input  logic              reset,
  poly_note_player_if.slave bus
);

  localparam int ACC_W = SAMPLE_W + VOICE_BITS + 1;
  localparam logic [VOICE_BITS-1:0] LAST_VOICE = VOICE_BITS'(NUM_VOICES - 1);

  logic [NOTE_W-1:0]     note  [NUM_VOICES];
  logic [DUR_W-1:0]      count [NUM_VOICES];
  logic [PHASE_W-1:0]    phase [NUM_VOICES];
  logic [NUM_VOICES-1:0] load_hit;
  logic [NUM_VOICES-1:0] done;
  logic                  beat_tick;

  logic [2:0]              state;
  logic [VOICE_BITS-1:0]   idx;
  logic signed [ACC_W-1:0] acc;
  logic [SAMPLE_W-1:0]     sample_q;
  logic                    ready_q;

  logic [STEP_W-1:0]      freq_dout;
  logic [SINE_ADDR_W-1:0] sine_addr;
  logic [SAMPLE_W-1:0]    sine_dout;
  logic                   sine_neg;
  logic                   voice_silent;

  logic                    voice_live;
  logic                    voice_active;
  logic [STEP_W-1:0]       step;
  logic [PHASE_W-1:0]      next_phase;
  logic [SAMPLE_W-1:0]     voice_sample;
  logic signed [ACC_W-1:0] voice_ext;
  logic signed [ACC_W-1:0] shifted;
  logic [SAMPLE_W-1:0]     sat_sample;

  assign beat_tick = bus.beat & bus.play_enable;

  // Out-of-range voice_sel matches no voice, so such loads fall away here.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign load_hit[v] = bus.load_new_note && (bus.voice_sel == VOICE_BITS'(v));

    voice_timer u_timer (
      .clk       (clk),
      .reset     (reset),
      .load      (load_hit[v]),
      .beat_tick (beat_tick),
      .note_in   (bus.note_to_load),
      .dur_in    (bus.duration_to_load),
      .note      (note[v]),
      .count     (count[v]),
      .done      (done[v])
    );
  end

  // A live voice is sounding; only an active one (live and playing) advances its phase.
  always_comb begin
    voice_live   = (count[idx] != '0) && (note[idx] != '0);
    voice_active = bus.play_enable && voice_live;
    step         = voice_active ? freq_dout : '0;
    next_phase   = phase[idx] + PHASE_W'(step);
  end

  // Loads reset the phase and win over a STEP update of the same voice.
  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (reset || load_hit[v]) begin
        phase[v] <= '0;
      end else if (state == S_STEP && idx == VOICE_BITS'(v)) begin
        phase[v] <= next_phase;
      end
    end
  end

  // Shared ROMs, both with one cycle of read latency. The frequency ROM is
  // addressed by the current voice's note (valid in STEP); the sine ROM reads
  // the address captured in STEP (valid in ACC).
  always_ff @(posedge clk) begin
    if (reset) begin
      freq_dout <= '0;
      sine_dout <= '0;
    end else begin
      freq_dout <= freq_rom_value(note[idx]);
      sine_dout <= sine_rom_value(sine_addr);
    end
  end

  always_comb begin
    if (voice_silent) begin
      voice_sample = '0;
    end else if (sine_neg) begin
      voice_sample = -sine_dout;
    end else begin
      voice_sample = sine_dout;
    end
    voice_ext = {{(ACC_W - SAMPLE_W){voice_sample[SAMPLE_W-1]}}, voice_sample};

    // In range when every bit from the sample sign bit upward agrees.
    shifted = acc >>> MIX_SHIFT;
    if (&shifted[ACC_W-1:SAMPLE_W-1] || ~|shifted[ACC_W-1:SAMPLE_W-1]) begin
      sat_sample = shifted[SAMPLE_W-1:0];
    end else if (shifted[ACC_W-1]) begin
      sat_sample = {1'b1, {(SAMPLE_W - 1){1'b0}}};
    end else begin
      sat_sample = {1'b0, {(SAMPLE_W - 1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      idx          <= '0;
      acc          <= '0;
      sample_q     <= '0;
      ready_q      <= 1'b0;
      sine_addr    <= '0;
      sine_neg     <= 1'b0;
      voice_silent <= 1'b1;
    end else begin
      ready_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.generate_next_sample) begin
            acc   <= '0;
            idx   <= '0;
            state <= S_ADDR;
          end
        end
        S_ADDR: state <= S_STEP;
        S_STEP: begin
          // Quadrants 1 and 3 read the quarter table backwards; 2 and 3 negate.
          sine_addr    <= next_phase[20] ? ~next_phase[19:10] : next_phase[19:10];
          sine_neg     <= next_phase[21];
          voice_silent <= !voice_live;
          state        <= S_SINE;
        end
        S_SINE: state <= S_ACC;
        S_ACC: begin
          acc <= acc + voice_ext;
          if (idx == LAST_VOICE) begin
            state <= S_OUT;
          end else begin
            idx   <= idx + VOICE_BITS'(1);
            state <= S_ADDR;
          end
        end
        S_OUT: begin
          sample_q <= sat_sample;
          ready_q  <= 1'b1;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.done_with_note   = done;
  assign bus.busy             = (state != S_IDLE);
  assign bus.sample_out       = sample_q;
  assign bus.new_sample_ready = ready_q;

endmodule

// File: tb/tb_poly_note_player.sv
// tb/tb_poly_note_player.sv - self-checking bench for poly_note_player against a behavioural voice model
module tb_poly_note_player;

  localparam int NV = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play_enable = 1'b0;
  logic       load_new_note = 1'b0;
  logic [1:0] voice_sel = 2'd0;
  logic [5:0] note_to_load = 6'd0;
  logic [5:0] duration_to_load = 6'd0;
  logic       beat = 1'b0;
  logic       gen = 1'b0;

  int total = 0;
  int bad = 0;

  int m_note  [NV];
  int m_count [NV];
  int m_phase [NV];

  always #5 clk = ~clk;

  poly_note_player_if #(.NUM_VOICES(NV), .VOICE_BITS(2)) bus_a ();
  poly_note_player_if #(.NUM_VOICES(NV), .VOICE_BITS(2)) bus_b ();

  assign bus_a.play_enable          = play_enable;
  assign bus_a.load_new_note        = load_new_note;
  assign bus_a.voice_sel            = voice_sel;
  assign bus_a.note_to_load         = note_to_load;
  assign bus_a.duration_to_load     = duration_to_load;
  assign bus_a.beat                 = beat;
  assign bus_a.generate_next_sample = gen;
  assign bus_b.play_enable          = play_enable;
  assign bus_b.load_new_note        = load_new_note;
  assign bus_b.voice_sel            = voice_sel;
  assign bus_b.note_to_load         = note_to_load;
  assign bus_b.duration_to_load     = duration_to_load;
  assign bus_b.beat                 = beat;
  assign bus_b.generate_next_sample = gen;

  poly_note_player #(.NUM_VOICES(NV), .VOICE_BITS(2), .MIX_SHIFT(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  poly_note_player #(.NUM_VOICES(NV), .VOICE_BITS(2), .MIX_SHIFT(0)) dut_ns (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  // ---------------- reference model ----------------
  function automatic int ref_sine(input int ph);
    int quadrant;
    int a;
    int amp;
    quadrant = ph / 1048576;
    a = (ph / 1024) % 1024;
    if (quadrant == 1 || quadrant == 3) a = 1023 - a;
    amp = (a * (2048 - a)) / 32;
    return (quadrant >= 2) ? -amp : amp;
  endfunction

  function automatic int ref_clamp(input int x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return x;
  endfunction

  function automatic logic [2:0] model_done();
    logic [2:0] d;
    for (int v = 0; v < NV; v++) d[v] = (m_count[v] == 0);
    return d;
  endfunction

  task automatic model_clear();
    for (int v = 0; v < NV; v++) begin
      m_note[v] = 0;
      m_count[v] = 0;
      m_phase[v] = 0;
    end
  endtask

  task automatic model_mix(output int exp_a, output int exp_b);
    int sum;
    sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_count[v] != 0 && m_note[v] != 0) begin
        if (play_enable) m_phase[v] = (m_phase[v] + m_note[v] * 16384) % 4194304;
        sum += ref_sine(m_phase[v]);
      end
    end
    exp_a = ref_clamp(sum >>> 1);
    exp_b = ref_clamp(sum);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    model_clear();
  endtask

  task automatic do_load(input int v, input int n, input int d, input bit with_beat);
    voice_sel = 2'(v);
    note_to_load = 6'(n);
    duration_to_load = 6'(d);
    load_new_note = 1'b1;
    beat = with_beat;
    tick();
    load_new_note = 1'b0;
    beat = 1'b0;
    if (with_beat && play_enable) begin
      for (int k = 0; k < NV; k++) if (m_count[k] != 0) m_count[k]--;
    end
    if (v < NV) begin
      m_note[v] = n;
      m_count[v] = d;
      m_phase[v] = 0;
    end
  endtask

  task automatic do_beat();
    beat = 1'b1;
    tick();
    beat = 1'b0;
    if (play_enable) begin
      for (int k = 0; k < NV; k++) if (m_count[k] != 0) m_count[k]--;
    end
  endtask

  task automatic request(output int s_a, output int s_b, output int lat, output int busy_cyc);
    gen = 1'b1;
    tick();
    gen = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (bus_a.new_sample_ready !== 1'b1 && lat < 40) begin
      if (bus_a.busy === 1'b1) busy_cyc++;
      tick();
      lat++;
    end
    s_a = int'($signed(bus_a.sample_out));
    s_b = int'($signed(bus_b.sample_out));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    apply_reset();
    total++; if (bus_a.sample_out !== 16'd0) begin bad++; $display("FAIL reset_sample: got %0d want 0", bus_a.sample_out); end
    total++; if (bus_a.new_sample_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", bus_a.new_sample_ready); end
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
    total++; if (bus_a.done_with_note !== 3'b111) begin bad++; $display("FAIL reset_done: got %b want 111", bus_a.done_with_note); end
  endtask

  task automatic test_rest_mix();
    int ea, eb, sa, sb, lat, bc;
    play_enable = 1'b1;
    model_mix(ea, eb);
    request(sa, sb, lat, bc);
    total++; if (lat !== 14) begin bad++; $display("FAIL rest_latency: got %0d want 14", lat); end
    total++; if (bc !== 13) begin bad++; $display("FAIL rest_busy_cycles: got %0d want 13", bc); end
    total++; if (sa !== ea) begin bad++; $display("FAIL rest_sample: got %0d want %0d", sa, ea); end
    total++; if (bus_b.new_sample_ready !== 1'b1) begin bad++; $display("FAIL rest_ready_ns: got %b want 1", bus_b.new_sample_ready); end
    tick();
    total++; if (bus_a.new_sample_ready !== 1'b0) begin bad++; $display("FAIL rest_ready_pulse: got %b want 0", bus_a.new_sample_ready); end
  endtask

  task automatic test_duration();
    play_enable = 1'b1;
    do_load(1, 20, 3, 1'b0);
    total++; if (bus_a.done_with_note !== 3'b101) begin bad++; $display("FAIL dur_load_done: got %b want 101", bus_a.done_with_note); end
    do_beat();
    do_beat();
    total++; if (bus_a.done_with_note[1] !== 1'b0) begin bad++; $display("FAIL dur_two_beats: got %b want 0", bus_a.done_with_note[1]); end
    do_beat();
    total++; if (bus_a.done_with_note[1] !== 1'b1) begin bad++; $display("FAIL dur_three_beats: got %b want 1", bus_a.done_with_note[1]); end
    play_enable = 1'b0;
    do_load(1, 20, 3, 1'b0);
    do_beat();
    do_beat();
    do_beat();
    total++; if (bus_a.done_with_note[1] !== 1'b0) begin bad++; $display("FAIL dur_paused_beats: got %b want 0", bus_a.done_with_note[1]); end
    play_enable = 1'b1;
    do_beat();
    do_beat();
    total++; if (bus_a.done_with_note[1] !== 1'b0) begin bad++; $display("FAIL dur_resume_two: got %b want 0", bus_a.done_with_note[1]); end
    do_beat();
    total++; if (bus_a.done_with_note[1] !== 1'b1) begin bad++; $display("FAIL dur_resume_three: got %b want 1", bus_a.done_with_note[1]); end
  endtask

  task automatic test_single_tone();
    int ea, eb, sa, sb, lat, bc;
    apply_reset();
    play_enable = 1'b1;
    do_load(0, 40, 10, 1'b0);
    for (int i = 0; i < 8; i++) begin
      model_mix(ea, eb);
      request(sa, sb, lat, bc);
      total++; if (lat !== 14) begin bad++; $display("FAIL tone_latency[%0d]: got %0d want 14", i, lat); end
      total++; if (sa !== ea) begin bad++; $display("FAIL tone_sample[%0d]: got %0d want %0d", i, sa, ea); end
      total++; if (sb !== eb) begin bad++; $display("FAIL tone_sample_ns[%0d]: got %0d want %0d", i, sb, eb); end
    end
  endtask

  task automatic test_saturation();
    int ea, eb, sa, sb, lat, bc;
    bit seen_max, seen_min;
    seen_max = 1'b0;
    seen_min = 1'b0;
    apply_reset();
    play_enable = 1'b1;
    for (int v = 0; v < NV; v++) do_load(v, 40, 63, 1'b0);
    for (int i = 0; i < 10; i++) begin
      model_mix(ea, eb);
      request(sa, sb, lat, bc);
      total++; if (sb !== eb) begin bad++; $display("FAIL sat_sample_ns[%0d]: got %0d want %0d", i, sb, eb); end
      total++; if (sa !== ea) begin bad++; $display("FAIL sat_sample[%0d]: got %0d want %0d", i, sa, ea); end
      if (sb == 32767) seen_max = 1'b1;
      if (sb == -32768) seen_min = 1'b1;
    end
    total++; if (seen_max !== 1'b1) begin bad++; $display("FAIL sat_pos_clamp: got %b want 1", seen_max); end
    total++; if (seen_min !== 1'b1) begin bad++; $display("FAIL sat_neg_clamp: got %b want 1", seen_min); end
  endtask

  task automatic test_busy_ignore();
    int ea, eb, sa, rdy_cnt, first;
    sa = 0;
    rdy_cnt = 0;
    first = 0;
    model_mix(ea, eb);
    gen = 1'b1;
    tick();
    gen = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (bus_a.new_sample_ready === 1'b1) begin
        rdy_cnt++;
        if (first == 0) begin
          first = c;
          sa = int'($signed(bus_a.sample_out));
        end
      end
      gen = (c == 5 || c == 9);
      tick();
    end
    gen = 1'b0;
    total++; if (first !== 14) begin bad++; $display("FAIL busy_first_ready: got %0d want 14", first); end
    total++; if (rdy_cnt !== 1) begin bad++; $display("FAIL busy_ready_count: got %0d want 1", rdy_cnt); end
    total++; if (sa !== ea) begin bad++; $display("FAIL busy_sample: got %0d want %0d", sa, ea); end
  endtask

  task automatic test_bad_voice();
    int ea, eb, sa, sb, lat, bc;
    apply_reset();
    play_enable = 1'b1;
    do_load(0, 10, 5, 1'b0);
    do_load(3, 50, 20, 1'b0);
    total++; if (bus_a.done_with_note !== 3'b110) begin bad++; $display("FAIL badsel_done: got %b want 110", bus_a.done_with_note); end
    for (int i = 0; i < 2; i++) begin
      model_mix(ea, eb);
      request(sa, sb, lat, bc);
      total++; if (sa !== ea) begin bad++; $display("FAIL badsel_sample[%0d]: got %0d want %0d", i, sa, ea); end
    end
  endtask

  task automatic test_load_beat();
    apply_reset();
    play_enable = 1'b1;
    do_load(0, 7, 1, 1'b0);
    do_load(2, 9, 5, 1'b1);
    total++; if (bus_a.done_with_note !== 3'b011) begin bad++; $display("FAIL ldbeat_done: got %b want 011", bus_a.done_with_note); end
    for (int i = 0; i < 4; i++) do_beat();
    total++; if (bus_a.done_with_note[2] !== 1'b0) begin bad++; $display("FAIL ldbeat_four: got %b want 0", bus_a.done_with_note[2]); end
    do_beat();
    total++; if (bus_a.done_with_note[2] !== 1'b1) begin bad++; $display("FAIL ldbeat_five: got %b want 1", bus_a.done_with_note[2]); end
  endtask

  task automatic test_reset_mid_mix();
    int rdy_cnt;
    rdy_cnt = 0;
    apply_reset();
    play_enable = 1'b1;
    do_load(0, 40, 10, 1'b0);
    gen = 1'b1;
    tick();
    gen = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_clear();
    total++; if (bus_a.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", bus_a.busy); end
    total++; if (bus_a.done_with_note !== model_done()) begin bad++; $display("FAIL midrst_done: got %b want %b", bus_a.done_with_note, model_done()); end
    for (int c = 0; c < 20; c++) begin
      if (bus_a.new_sample_ready === 1'b1) rdy_cnt++;
      tick();
    end
    total++; if (rdy_cnt !== 0) begin bad++; $display("FAIL midrst_ready: got %0d want 0", rdy_cnt); end
    total++; if (bus_a.sample_out !== 16'd0) begin bad++; $display("FAIL midrst_sample: got %0d want 0", bus_a.sample_out); end
  endtask

  task automatic test_random();
    int ea, eb, sa, sb, lat, bc, ops, r;
    apply_reset();
    play_enable = 1'b1;
    for (int i = 0; i < 30; i++) begin
      ops = $urandom_range(1, 3);
      for (int k = 0; k < ops; k++) begin
        r = $urandom_range(0, 3);
        if (r <= 1) begin
          do_load($urandom_range(0, 3),
                  ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 63),
                  $urandom_range(0, 6), 1'($urandom_range(0, 1)));
        end else if (r == 2) begin
          do_beat();
        end else begin
          play_enable = ($urandom_range(0, 3) != 0);
        end
      end
      model_mix(ea, eb);
      request(sa, sb, lat, bc);
      total++; if (sa !== ea) begin bad++; $display("FAIL rand_sample[%0d]: got %0d want %0d", i, sa, ea); end
      total++; if (sb !== eb) begin bad++; $display("FAIL rand_sample_ns[%0d]: got %0d want %0d", i, sb, eb); end
      total++; if (bus_a.done_with_note !== model_done()) begin bad++; $display("FAIL rand_done[%0d]: got %b want %b", i, bus_a.done_with_note, model_done()); end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_rest_mix();
    test_duration();
    test_single_tone();
    test_saturation();
    test_busy_ignore();
    test_bad_voice();
    test_load_beat();
    test_reset_mid_mix();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
